// File: rtl/button_press_driver.sv
// Open-drain button press emulator: drives N low pulses of PRESS_CYCLES,
// each followed by a RELEASE_CYCLES gap, with start/busy/done and abort.
module button_press_driver #(
    parameter int PRESS_CYCLES   = 200,
    parameter int RELEASE_CYCLES = 200,
    parameter int COUNT_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_start,
    input  logic [COUNT_WIDTH-1:0] in_count,
    input  logic                   in_abort,
    output logic                   out_pin_low,
    output logic                   out_busy,
    output logic                   out_done,
    output logic                   out_aborted
);

    localparam int MAX_CYCLES =
        (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int PW = $clog2(MAX_CYCLES + 1);

    localparam logic [PW-1:0] PRESS_LOAD   = PW'(PRESS_CYCLES - 1);
    localparam logic [PW-1:0] RELEASE_LOAD = PW'(RELEASE_CYCLES - 1);
    localparam logic [PW-1:0] PH_ONE       = PW'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] remain_q, remain_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic                   abort_q, abort_d;

    logic pin_q, pin_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic aborted_q, aborted_d;

    // Phase counter loads (length-1) on entry and the state is left when it hits zero.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        phase_d  = phase_q;
        abort_d  = abort_q;

        unique case (state_q)
            IDLE: begin
                if (in_start) begin
                    abort_d = 1'b0;
                    if (in_count != '0) begin
                        remain_d = in_count;
                        phase_d  = PRESS_LOAD;
                        state_d  = PRESS;
                    end else begin
                        phase_d = '0;
                        state_d = DONE;
                    end
                end
            end

            PRESS: begin
                if (in_abort) begin
                    remain_d = '0;
                    abort_d  = 1'b1;
                    phase_d  = RELEASE_LOAD;
                    state_d  = RELEASE;
                end else if (phase_q == '0) begin
                    remain_d = remain_q - CNT_ONE;
                    phase_d  = RELEASE_LOAD;
                    state_d  = RELEASE;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end

            RELEASE: begin
                if (in_abort) begin
                    remain_d = '0;
                    abort_d  = 1'b1;
                end
                // The gap always runs to completion, even when aborted.
                if (phase_q == '0) begin
                    if (remain_d != '0) begin
                        phase_d = PRESS_LOAD;
                        state_d = PRESS;
                    end else begin
                        phase_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end

            DONE: begin
                phase_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pin_d     = (state_d == PRESS);
        busy_d    = (state_d == PRESS) || (state_d == RELEASE);
        done_d    = (state_d == DONE);
        aborted_d = (state_d == DONE) && abort_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            phase_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            phase_q  <= phase_d;
            abort_q  <= abort_d;
        end
    end

    // Outputs are flops so the open-drain enable is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            pin_q     <= pin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign out_pin_low = pin_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;
    assign out_aborted = aborted_q;

endmodule

// File: tb/tb_button_press_driver.sv
// Bench for button_press_driver: cycle-by-cycle expected outputs
// are queued from a behavioural model and popped each clock.
module tb_button_press_driver;

    localparam int P  = 3;
    localparam int R  = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_start;
    logic [CW-1:0] in_count;
    logic          in_abort;
    logic          out_pin_low;
    logic          out_busy;
    logic          out_done;
    logic          out_aborted;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb[$];

    button_press_driver #(
        .PRESS_CYCLES  (P),
        .RELEASE_CYCLES(R),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_start   (in_start),
        .in_count   (in_count),
        .in_abort   (in_abort),
        .out_pin_low(out_pin_low),
        .out_busy   (out_busy),
        .out_done   (out_done),
        .out_aborted(out_aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] outs();
        return {out_pin_low, out_busy, out_done, out_aborted};
    endfunction

    task automatic check(string tag, int cyc, logic [3:0] got,
                         logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: got pin/busy/done/abt=%b expected %b",
                   tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(bit pin, bit busy, bit done, bit ab);
        sb.push_back({pin, busy, done, ab});
    endtask

    // Expected outputs for cycles 1.. after an accepting edge at cycle 0,
    // plus one trailing idle cycle.
    task automatic model_seq(int cnt, int abort_at);
        int c = 1;
        bit ab = 1'b0;
        for (int i = 0; i < cnt && !ab; i++) begin
            for (int p = 0; p < P; p++) begin
                push(1, 1, 0, 0);
                if (c == abort_at) ab = 1'b1;
                c++;
                if (ab) break;
            end
            for (int r = 0; r < R; r++) begin
                push(0, 1, 0, 0);
                if (c == abort_at) ab = 1'b1;
                c++;
            end
        end
        push(0, 0, 1, ab);
        push(0, 0, 0, 0);
    endtask

    // Caller has set cycle-0 inputs; runs until the scoreboard drains.
    task automatic play(string tag, int abort_at, logic [31:0] start_mask);
        int c = 1;
        logic [3:0] exp;
        while (sb.size() > 0 && c < 500) begin
            tick();
            exp = sb.pop_front();
            check(tag, c, outs(), exp);
            in_start = (c < 32) ? start_mask[c] : 1'b0;
            in_count = in_start ? CW'(5) : '0;
            in_abort = (c == abort_at);
            c++;
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        in_start = 1'b0;
        in_count = '0;
        in_abort = 1'b0;

        #2 rst_n = 1'b0;
        #1 check("reset_imm", 0, outs(), 4'b0000);
        in_start = 1'b1;
        in_count = CW'(3);
        in_abort = 1'b1;
        @(posedge clk);
        #1 check("reset_hold1", 0, outs(), 4'b0000);
        in_abort = 1'b0;
        @(posedge clk);
        #1 check("reset_hold2", 0, outs(), 4'b0000);
        in_start = 1'b0;
        in_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset", 0, outs(), 4'b0000);

        in_start = 1'b1;
        in_count = CW'(2);
        model_seq(2, -1);
        play("cnt2", -1, 32'h0);

        in_start = 1'b1;
        in_count = CW'(0);
        model_seq(0, -1);
        play("cnt0", -1, 32'h0);

        in_start = 1'b1;
        in_count = CW'(1);
        model_seq(1, -1);
        play("cnt1_nostart", -1, (32'h1 << 2) | (32'h1 << 4) | (32'h1 << 6));

        in_start = 1'b1;
        in_count = CW'(1);
        model_seq(1, -1);
        play("cnt1_late", -1, 32'h0);

        in_start = 1'b1;
        in_count = CW'(3);
        model_seq(3, 7);
        play("abort_press", 7, 32'h0);

        in_start = 1'b1;
        in_count = CW'(2);
        model_seq(2, 4);
        play("abort_rel", 4, 32'h0);

        in_start = 1'b1;
        in_abort = 1'b1;
        in_count = CW'(1);
        model_seq(1, -1);
        play("start_abort", -1, 32'h0);

        in_start = 1'b1;
        in_count = CW'(2);
        tick();
        check("rst_mid_c1", 1, outs(), 4'b1100);
        in_start = 1'b0;
        tick();
        check("rst_mid_c2", 2, outs(), 4'b1100);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_async", 2, outs(), 4'b0000);
        in_start = 1'b1;
        in_abort = 1'b1;
        in_count = CW'(7);
        tick();
        check("rst_mid_hold", 3, outs(), 4'b0000);
        in_start = 1'b0;
        in_abort = 1'b0;
        in_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_idle1", 0, outs(), 4'b0000);
        tick();
        check("rst_idle2", 0, outs(), 4'b0000);

        in_start = 1'b1;
        in_count = CW'(2);
        model_seq(2, -1);
        play("fresh", -1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_press_driver.md
Name: button_press_driver

Overview:
- Output-side counterpart of the debounced pull-up button input: emulates a switch to GND on an open-drain pin.
- Used to "press" a button input on another device, or on our own board in loopback.
- On a start request, generates N low pulses of exactly PRESS_CYCLES, each followed by a release gap of exactly RELEASE_CYCLES.
- Timing is chosen so a debouncer at the far end registers each press exactly once. Start/busy/done handshake, with abort.

Parameters:
- PRESS_CYCLES, 200, cycles the pin is driven low per press (>=1; must exceed far-end debounce cycles).
- RELEASE_CYCLES, 200, cycles the pin is released after each press (>=1; must exceed far-end debounce cycles).
- COUNT_WIDTH, 4, width of press-count input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_start  in  1  request; sampled only in IDLE.
- in_count  in  COUNT_WIDTH  number of presses, latched on accepted start.
- in_abort  in  1  cancel remaining presses.
- out_pin_low  out  1  1 = drive pin to GND; 0 = release (pin is pulled up). Registered output. Feeds the open-drain output-enable.
- out_busy  out  1  high while a sequence is in progress.
- out_done  out  1  one-cycle pulse at sequence end.
- out_aborted  out  1  valid with out_done; 1 if the sequence was aborted.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; out_pin_low=0, out_busy=0, out_done=0, out_aborted=0; counters cleared. Pin release must not wait for a clock edge.
- States: IDLE, PRESS, RELEASE, DONE.
- IDLE:
  - If in_start=1 and in_count!=0: latch in_count into the remaining-press counter, go to PRESS.
  - If in_start=1 and in_count=0: go to DONE directly, pin untouched.
  - Otherwise stay in IDLE.
- PRESS: out_pin_low=1 and out_busy=1 for exactly PRESS_CYCLES cycles, starting the cycle after the accepting edge. Then decrement the remaining count and go to RELEASE.
- RELEASE: out_pin_low=0 and out_busy=1 for exactly RELEASE_CYCLES cycles. Then go to PRESS if the remaining count is nonzero, else go to DONE.
- DONE: lasts one cycle; out_done=1, out_busy=0, out_aborted holds the sticky abort flag. Next state is always IDLE.
- Start handshake:
  - in_start is ignored in PRESS, RELEASE and DONE; there is no queueing.
  - The earliest new accept is the IDLE cycle after DONE.
- Abort:
  - In PRESS: pin released on the next edge; remaining count cleared; abort flag set. Then a full RELEASE_CYCLES gap (never truncated), then DONE with out_aborted=1.
  - In RELEASE: remaining count cleared; abort flag set; the current gap runs to completion, then DONE.
  - Ignored in IDLE and DONE.
  - in_start and in_abort on the same IDLE edge: start wins, abort ignored.
- Abort flag cleared on accepted start and on reset. out_aborted is 0 except in the DONE cycle.
- Phase counter:
  - Width $clog2(max(PRESS_CYCLES,RELEASE_CYCLES)+1).
  - Reloaded on every state entry; no wrap-around ever occurs.
- Total latency, start edge to out_done (no abort): in_count*(PRESS_CYCLES+RELEASE_CYCLES)+1 cycles.
- Pulse-width guarantee: every low pulse is exactly PRESS_CYCLES long, except one truncated by abort. Every gap is exactly RELEASE_CYCLES long, no exceptions.

Test Plan (PRESS_CYCLES=3, RELEASE_CYCLES=2, COUNT_WIDTH=4; accepting edge = cycle 0):
- Reset: assert rst_n=0 between clock edges -> all outputs 0 immediately. Inputs toggled during reset -> outputs stay 0.
- in_count=2, start at cycle 0:
  - out_pin_low=1 in cycles 1-3 and 6-8, 0 in cycles 4-5 and 9-10.
  - out_busy=1 in cycles 1-10.
  - out_done=1 only in cycle 11, with out_aborted=0.
- in_count=0 start -> out_done=1 in cycle 1; out_pin_low and out_busy never 1.
- in_count=1 start, then in_start=1 with in_count=5 at cycles 2, 4 and 6 -> exactly 1 press; done in cycle 6. The start at cycle 6 (DONE) is ignored; a start at cycle 7 is accepted.
- in_count=3, in_abort=1 at cycle 7 (second press) -> out_pin_low=0 from cycle 8; released through cycle 9; out_done=1 with out_aborted=1 in cycle 10; no third press.
- in_count=2, rst_n dropped mid-cycle 2 -> out_pin_low falls without a clock edge. After release, outputs stay idle until a new start; a new start behaves as a fresh sequence.
